// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;

    localparam int DW_A_DEF = 8;
    localparam int DW_B_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module divider_step #(
    parameter int DW_B = divider_pkg::DW_B_DEF
) (
    input  logic [DW_B-1:0] rem_in,
    input  logic            bit_in,
    input  logic [DW_B-1:0] divisor,
    output logic [DW_B-1:0] rem_out,
    output logic            q_bit
);

    logic [DW_B:0] partial_s;
    logic [DW_B:0] diff_s;

    // Compare-and-subtract on the widened partial remainder.
    always_comb begin
        partial_s = {rem_in, bit_in};
        diff_s    = partial_s - {1'b0, divisor};
        if (partial_s >= {1'b0, divisor}) begin
            rem_out = diff_s[DW_B-1:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = partial_s[DW_B-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned divider, one quotient bit per cycle, MSB first.
// Define DIVIDER_SEQ_DBZ_EN to short-circuit divide-by-zero and raise dbz.
module divider_seq
    import divider_pkg::*;
#(
    parameter int DW_A = DW_A_DEF,
    parameter int DW_B = DW_B_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW_A-1:0] dividend,
    input  logic [DW_B-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [DW_A-1:0] quotient,
    output logic [DW_B-1:0] remainder,
    output logic            dbz
);

    localparam int CW = $clog2(DW_A + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW_B-1:0] rem_q, rem_d;
    logic [DW_A-1:0] work_q, work_d;
    logic [DW_B-1:0] dvs_q, dvs_d;
    logic [DW_A-1:0] quot_q, quot_d;
    logic [DW_B-1:0] remd_q, remd_d;
    logic            dbz_q, dbz_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            pend_q, pend_d;

    logic [DW_B-1:0] step_rem_s;
    logic            step_qbit_s;

    // work_q shifts dividend bits out at the top and quotient bits in at the bottom.
    divider_step #(.DW_B(DW_B)) u_step (
        .rem_in  (rem_q),
        .bit_in  (work_q[DW_A-1]),
        .divisor (dvs_q),
        .rem_out (step_rem_s),
        .q_bit   (step_qbit_s)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
        pend_d  = 1'b0;
        if (pend_q) begin
            // Divide-by-zero short path: results come straight from the latched dividend.
            state_d = DONE;
            quot_d  = {DW_A{1'b1}};
            remd_d  = work_q[DW_B-1:0];
            dbz_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        work_d  = dividend;
                        dvs_d   = divisor;
                        rem_d   = {DW_B{1'b0}};
                        cnt_d   = {CW{1'b0}};
`ifdef DIVIDER_SEQ_DBZ_EN
                        if (divisor == {DW_B{1'b0}}) begin
                            pend_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                        end
`else
                        state_d = RUN;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    rem_d  = step_rem_s;
                    work_d = {work_q[DW_A-2:0], step_qbit_s};
                    cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(DW_A - 1)) begin
                        state_d = DONE;
                        quot_d  = {work_q[DW_A-2:0], step_qbit_s};
                        remd_d  = step_rem_s;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        done_d = (state_d == DONE);
        busy_d = (state_d == RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {DW_B{1'b0}};
            work_q  <= {DW_A{1'b0}};
            dvs_q   <= {DW_B{1'b0}};
            quot_q  <= {DW_A{1'b0}};
            remd_q  <= {DW_B{1'b0}};
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remd_q;
    assign dbz       = dbz_q;

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL declare parameter DW_A, default 8, meaning the dividend and quotient width.
REQ-002 The block SHALL declare parameter DW_B, default 4, meaning the divisor and remainder width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a division.
REQ-006 The block SHALL have port dividend, input, DW_A bits: unsigned numerator, sampled at the accept edge.
REQ-007 The block SHALL have port divisor, input, DW_B bits: unsigned denominator, sampled at the accept edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-010 The block SHALL have port quotient, output, DW_A bits: unsigned result.
REQ-011 The block SHALL have port remainder, output, DW_B bits: unsigned result.
REQ-012 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag, valid with done.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 A start=1 sampled in IDLE or DONE SHALL be accepted: operands are latched, the iteration count is cleared, and the FSM enters RUN.
REQ-015 A start sampled in RUN SHALL be ignored; operands and progress are unaffected.
REQ-016 RUN SHALL perform one restoring-division step per cycle, MSB of the dividend first, for exactly DW_A cycles.
- Each step: partial remainder (DW_B+1 bits) = {rem, next dividend bit}.
- If partial remainder >= divisor: subtract the divisor and shift in a quotient bit of 1; otherwise shift in 0.
REQ-017 The accept edge being edge k, the FSM SHALL enter DONE at edge k+DW_A; done=1 and final results SHALL be visible in the following cycle (latency DW_A cycles).
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL return to IDLE next unless start=1, in which case it SHALL go to RUN (back-to-back).
REQ-019 busy SHALL be 1 exactly while in RUN.
REQ-020 quotient, remainder and dbz SHALL hold their last values until the next accept edge; intermediate values SHALL NOT be visible on these outputs during RUN.
REQ-021 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.

Reset
REQ-022 When rst=1 at an edge, the FSM SHALL go to IDLE, and busy, done, dbz, quotient and remainder SHALL be 0; this takes precedence over start and applies mid-RUN, and the aborted division produces no done.

Configuration
REQ-023 With DIVIDER_SEQ_DBZ_EN defined, divisor==0 at accept SHALL skip RUN and go straight to DONE at edge k+1, with quotient all ones, remainder=dividend[DW_B-1:0] and dbz=1.
REQ-024 Without DIVIDER_SEQ_DBZ_EN, divisor==0 SHALL run the normal DW_A steps, yielding quotient all ones and remainder=dividend[DW_B-1:0], with dbz tied to 0.

Structure
REQ-025 Package divider_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and the default width constants.
REQ-026 The single step SHALL be a combinational sub-module divider_step: it takes the partial remainder, the incoming bit and the divisor, and returns the new remainder and the quotient bit.

Verification
REQ-027 The bench SHALL cover: 6/3 -> quotient=2, remainder=0, done 8 cycles after accept, busy high for 8 cycles.
REQ-028 The bench SHALL cover: 225/15 -> 15 r0; 200/7 -> 28 r4; 255/1 -> 255 r0; 5/12 -> 0 r5.
REQ-029 The bench SHALL cover: 100/0 with DIVIDER_SEQ_DBZ_EN -> done after 1 cycle, quotient=255, remainder=4, dbz=1; without the macro -> done after 8 cycles, same values, dbz=0.
REQ-030 The bench SHALL cover: start=1 with new operands during RUN -> ignored, and the original result is delivered.
REQ-031 The bench SHALL cover: start held high through DONE -> a second division starts back-to-back, with done pulses exactly 9 cycles apart.
REQ-032 The bench SHALL cover: rst asserted at RUN step 4 -> next cycle all outputs are 0, no done follows, and a new start then completes normally.
